// File: rtl/multicycle_ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the RV32I multi-cycle controller.
//   state_e   - controller FSM states
//   alu_op_e  - ALU operation codes driven on o_alu_op
//   imm_sel_e - immediate-generator select codes driven on o_imm_sel
//   dec_t     - decoded instruction summary produced by ctrl_decode
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I  = 3'b000,
        IMM_SH = 3'b001,
        IMM_S  = 3'b010,
        IMM_B  = 3'b011,
        IMM_J  = 3'b100,
        IMM_U  = 3'b101
    } imm_sel_e;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Writeback mux codes
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef struct packed {
        logic     illegal;
        logic     is_load;
        logic     is_store;
        logic     is_branch;
        logic     is_jump;    // JAL or JALR
        logic     wr_rd;      // writes the register file and rd != x0
        imm_sel_e imm_sel;
        alu_op_e  alu_op;
        logic     opa_sel;
        logic     opb_sel;
        logic     br_un;      // unsigned compare
        logic     br_lt;      // branch tests "less" rather than "equal"
        logic     br_neg;     // invert the compare result (BNE/BGE/BGEU)
    } dec_t;

    // funct3 -> ALU op; alt is funct7[5]. SUB only exists for register-register OP.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt,
                                            input logic is_op);
        alu_op_e op;
        case (f3)
            3'b000:  op = (is_op && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// ctrl_decode: combinational decode of the instruction register.
//   i_instr - IR contents
//   o_dec   - instruction class, immediate select, ALU op, operand selects,
//             branch condition and illegal flag
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] i_instr,
    output dec_t        o_dec
);

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_rd_nz;
    logic       w_shift;
    logic       w_shift_ok;
    logic       w_unused_bits;

    assign w_opc   = i_instr[6:0];
    assign w_f3    = i_instr[14:12];
    assign w_f7    = i_instr[31:25];
    assign w_rd_nz = |i_instr[11:7];
    assign w_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);
    // Only SRL/SRA may carry funct7 = 0100000; every other shift needs zero.
    assign w_shift_ok = (w_f7 == 7'h00) || ((w_f3 == 3'b101) && (w_f7 == 7'h20));
    // rs1/rs2 fields matter only to the datapath
    assign w_unused_bits = ^i_instr[24:15];

    always_comb begin
        o_dec         = '0;
        o_dec.imm_sel = IMM_I;
        o_dec.alu_op  = ALU_ADD;
        case (w_opc)
            OPC_LUI: begin
                o_dec.imm_sel = IMM_U;
                o_dec.alu_op  = ALU_PASS_B;
                o_dec.opb_sel = 1'b1;
                o_dec.wr_rd   = w_rd_nz;
            end
            OPC_AUIPC: begin
                o_dec.imm_sel = IMM_U;
                o_dec.opa_sel = 1'b1;
                o_dec.opb_sel = 1'b1;
                o_dec.wr_rd   = w_rd_nz;
            end
            OPC_JAL: begin
                o_dec.imm_sel = IMM_J;
                o_dec.opa_sel = 1'b1;
                o_dec.opb_sel = 1'b1;
                o_dec.is_jump = 1'b1;
                o_dec.wr_rd   = w_rd_nz;
            end
            OPC_JALR: begin
                o_dec.opb_sel = 1'b1;
                o_dec.is_jump = 1'b1;
                o_dec.wr_rd   = w_rd_nz;
            end
            OPC_BRANCH: begin
                // ALU forms the PC-relative target; the comparator decides.
                o_dec.imm_sel   = IMM_B;
                o_dec.opa_sel   = 1'b1;
                o_dec.opb_sel   = 1'b1;
                o_dec.is_branch = 1'b1;
                o_dec.br_un     = w_f3[1];
                o_dec.br_lt     = w_f3[2];
                o_dec.br_neg    = w_f3[0];
            end
            OPC_LOAD: begin
                o_dec.opb_sel = 1'b1;
                o_dec.is_load = 1'b1;
                o_dec.wr_rd   = w_rd_nz;
            end
            OPC_STORE: begin
                o_dec.imm_sel  = IMM_S;
                o_dec.opb_sel  = 1'b1;
                o_dec.is_store = 1'b1;
            end
            OPC_OPIMM: begin
                o_dec.opb_sel = 1'b1;
                o_dec.wr_rd   = w_rd_nz;
                o_dec.alu_op  = alu_from_f3(w_f3, w_f7[5], 1'b0);
                if (w_shift) begin
                    o_dec.imm_sel = IMM_SH;
                    o_dec.illegal = !w_shift_ok;
                end
            end
            OPC_OP: begin
                o_dec.wr_rd  = w_rd_nz;
                o_dec.alu_op = alu_from_f3(w_f3, w_f7[5], 1'b1);
                if (w_shift) o_dec.illegal = !w_shift_ok;
            end
            OPC_FENCE, OPC_SYSTEM: begin
                // retired as NOPs: pass through WB without a register write
            end
            default: o_dec.illegal = 1'b1;
        endcase
        if (o_dec.illegal) o_dec.wr_rd = 1'b0;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the RV32I multi-cycle datapath.
//   i_clk/i_rst_n        - clock, async active-low reset
//   i_instr              - IR contents (stable from S_DECODE on)
//   i_imem_valid         - fetch data valid
//   i_dmem_ready         - data access complete
//   i_br_less/i_br_equal - branch comparator flags
//   o_imem_req/o_ir_we   - fetch handshake and IR load
//   o_imm_sel, o_alu_op, o_opa_sel, o_opb_sel, o_br_un - datapath selects
//   o_dmem_req/o_dmem_we - data memory request / store
//   o_rd_wren, o_wb_sel  - register writeback
//   o_pc_we, o_pc_sel    - PC update (PC+4 or ALU target)
//   o_insn_vld, o_illegal - retire and illegal-instruction pulses
//
// Level outputs are registered on state entry. The few strobes that must react
// within the same cycle to a handshake or comparator input (IR load on fetch
// valid, store retire on dmem ready, branch direction) are gated combinationally
// from registered qualifiers, so reset forces every output low immediately.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter state_e RESET_STATE  = S_FETCH,
    parameter bit     ILLEGAL_TRAP = 1'b1
)(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_instr,
    input  logic        i_imem_valid,
    input  logic        i_dmem_ready,
    input  logic        i_br_less,
    input  logic        i_br_equal,
    output logic        o_imem_req,
    output logic        o_ir_we,
    output logic [2:0]  o_imm_sel,
    output logic [3:0]  o_alu_op,
    output logic        o_opa_sel,
    output logic        o_opb_sel,
    output logic        o_br_un,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic        o_rd_wren,
    output logic [1:0]  o_wb_sel,
    output logic        o_pc_we,
    output logic        o_pc_sel,
    output logic        o_insn_vld,
    output logic        o_illegal
);

    dec_t    w_dec;
    state_e  r_state;
    alu_op_e r_alu_op;
    logic    r_imem_req, r_dmem_req, r_dmem_we, r_rd_wren;
    logic    r_pc_we, r_pc_sel, r_insn_vld, r_illegal;
    logic    r_opa_sel, r_opb_sel, r_br_un, r_br_exec;
    logic [1:0] r_wb_sel;
    logic    w_taken, w_st_done, w_nop_retire;

    ctrl_decode u_decode (
        .i_instr (i_instr),
        .o_dec   (w_dec)
    );

    assign w_taken      = (w_dec.br_lt ? i_br_less : i_br_equal) ^ w_dec.br_neg;
    assign w_st_done    = r_dmem_req & r_dmem_we & i_dmem_ready;
    // With trapping disabled an illegal opcode retires straight out of DECODE.
    assign w_nop_retire = (r_state == S_DECODE) & w_dec.illegal & ~ILLEGAL_TRAP;

    assign o_imem_req = r_imem_req;
    assign o_ir_we    = r_imem_req & i_imem_valid;
    assign o_imm_sel  = (r_state == S_FETCH) ? IMM_I : w_dec.imm_sel;
    assign o_alu_op   = r_alu_op;
    assign o_opa_sel  = r_opa_sel;
    assign o_opb_sel  = r_opb_sel;
    assign o_br_un    = r_br_un;
    assign o_dmem_req = r_dmem_req;
    assign o_dmem_we  = r_dmem_we;
    assign o_rd_wren  = r_rd_wren;
    assign o_wb_sel   = r_wb_sel;
    assign o_pc_we    = r_pc_we | w_st_done | w_nop_retire;
    assign o_pc_sel   = r_pc_sel | (r_br_exec & w_taken);
    assign o_insn_vld = r_insn_vld | w_st_done | w_nop_retire;
    assign o_illegal  = r_illegal;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= RESET_STATE;
            r_imem_req <= 1'b0;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_rd_wren  <= 1'b0;
            r_wb_sel   <= WB_ALU;
            r_pc_we    <= 1'b0;
            r_pc_sel   <= 1'b0;
            r_insn_vld <= 1'b0;
            r_illegal  <= 1'b0;
            r_alu_op   <= ALU_ADD;
            r_opa_sel  <= 1'b0;
            r_opb_sel  <= 1'b0;
            r_br_un    <= 1'b0;
            r_br_exec  <= 1'b0;
        end else begin
            // single-cycle pulses default low
            r_rd_wren  <= 1'b0;
            r_wb_sel   <= WB_ALU;
            r_pc_we    <= 1'b0;
            r_pc_sel   <= 1'b0;
            r_insn_vld <= 1'b0;
            r_illegal  <= 1'b0;
            r_br_exec  <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    // The request is raised one clock after reset release.
                    if (r_imem_req && i_imem_valid) begin
                        r_imem_req <= 1'b0;
                        r_state    <= S_DECODE;
                    end else begin
                        r_imem_req <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (w_dec.illegal) begin
                        if (ILLEGAL_TRAP) begin
                            r_state    <= S_TRAP;
                            r_illegal  <= 1'b1;
                            r_pc_we    <= 1'b1;
                            r_insn_vld <= 1'b1;
                        end else begin
                            r_state    <= S_FETCH;
                            r_imem_req <= 1'b1;
                        end
                    end else begin
                        r_state   <= S_EXEC;
                        r_alu_op  <= w_dec.alu_op;
                        r_opa_sel <= w_dec.opa_sel;
                        r_opb_sel <= w_dec.opb_sel;
                        r_br_un   <= w_dec.br_un;
                        if (w_dec.is_branch) begin
                            r_pc_we    <= 1'b1;
                            r_insn_vld <= 1'b1;
                            r_br_exec  <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    if (w_dec.is_branch) begin
                        r_state    <= S_FETCH;
                        r_imem_req <= 1'b1;
                        r_alu_op   <= ALU_ADD;
                        r_opa_sel  <= 1'b0;
                        r_opb_sel  <= 1'b0;
                        r_br_un    <= 1'b0;
                    end else if (w_dec.is_load || w_dec.is_store) begin
                        r_state    <= S_MEM;
                        r_dmem_req <= 1'b1;
                        r_dmem_we  <= w_dec.is_store;
                    end else begin
                        r_state    <= S_WB;
                        r_rd_wren  <= w_dec.wr_rd;
                        r_wb_sel   <= w_dec.is_jump ? WB_PC4 : WB_ALU;
                        r_pc_we    <= 1'b1;
                        r_pc_sel   <= w_dec.is_jump;
                        r_insn_vld <= 1'b1;
                    end
                end
                S_MEM: begin
                    // ALU controls stay put so the address holds while waiting.
                    if (i_dmem_ready) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        if (w_dec.is_store) begin
                            r_state    <= S_FETCH;
                            r_imem_req <= 1'b1;
                            r_alu_op   <= ALU_ADD;
                            r_opa_sel  <= 1'b0;
                            r_opb_sel  <= 1'b0;
                        end else begin
                            r_state    <= S_WB;
                            r_rd_wren  <= w_dec.wr_rd;
                            r_wb_sel   <= WB_MEM;
                            r_pc_we    <= 1'b1;
                            r_insn_vld <= 1'b1;
                        end
                    end
                end
                default: begin
                    // S_WB and S_TRAP last one cycle and return to fetch
                    r_state    <= S_FETCH;
                    r_imem_req <= 1'b1;
                    r_alu_op   <= ALU_ADD;
                    r_opa_sel  <= 1'b0;
                    r_opb_sel  <= 1'b0;
                    r_br_un    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style control FSM that sequences the RV32I multi-cycle datapath: instruction fetch, decode, execute, memory access and writeback.
- Drives the immediate-generator select code, ALU op, operand and writeback muxes, register-file, PC and IR write enables, and the memory request handshakes.
- Sits beside the datapath and reads only the instruction register contents, the branch-comparator flags and the memory ready/valid strobes.

Parameters:
- RESET_STATE, S_FETCH, first state after reset.
- ILLEGAL_TRAP, 1, 1 = undecodable opcode goes to S_TRAP; 0 = treat it as a NOP.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_instr  in  32  IR output from the datapath; stable from S_DECODE onward.
- i_imem_valid  in  1  instruction memory read data valid.
- i_dmem_ready  in  1  data memory access complete.
- i_br_less  in  1  comparator rs1<rs2, signed or unsigned per o_br_un.
- i_br_equal  in  1  comparator rs1==rs2.
- o_imem_req  out  1  fetch request.
- o_ir_we  out  1  load IR.
- o_imm_sel  out  3  immediate select: 000 I, 001 shamt, 010 S, 011 B, 100 J, 101 U.
- o_alu_op  out  4  ALU operation (package enum).
- o_opa_sel  out  1  0 = rs1, 1 = PC.
- o_opb_sel  out  1  0 = rs2, 1 = imm.
- o_br_un  out  1  unsigned compare (BLTU/BGEU).
- o_dmem_req  out  1  data memory request.
- o_dmem_we  out  1  store.
- o_rd_wren  out  1  register-file write.
- o_wb_sel  out  2  00 ALU, 01 load data, 10 PC+4.
- o_pc_we  out  1  PC update.
- o_pc_sel  out  1  0 = PC+4, 1 = ALU target.
- o_insn_vld  out  1  retire pulse.
- o_illegal  out  1  illegal-instruction pulse.

Behaviour:
- Reset:
  - Asynchronous; state goes to S_FETCH.
  - All enables, requests and pulses are 0; o_imm_sel = 000; o_alu_op = ADD; all mux selects 0.
  - Reset asserted in any state, including mid-MEM, aborts the instruction with no rd or PC write.
- States: S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP.
- S_FETCH:
  - o_imem_req = 1 until i_imem_valid.
  - In the valid cycle, o_ir_we = 1 and next state is S_DECODE.
- S_DECODE (1 cycle):
  - Decode opcode/funct3/funct7 from i_instr.
  - Illegal opcode, or OP/OP-IMM shift with a bad funct7, goes to S_TRAP (or S_FETCH with PC+4 if ILLEGAL_TRAP = 0).
  - All other instructions go to S_EXEC.
- o_imm_sel is valid from S_DECODE until the instruction completes:
  - I-type: loads, JALR, non-shift OP-IMM.
  - shamt: SLLI/SRLI/SRAI.
  - S: stores.
  - B: branches.
  - J: JAL.
  - U: LUI, AUIPC.
- S_EXEC:
  - ALU computes the result or address; AUIPC and JAL use opa_sel = 1; LUI uses ALU op PASS_B.
  - Branch, in a single cycle:
    - taken = BEQ: eq; BNE: !eq; BLT/BLTU: less; BGE/BGEU: !less.
    - o_pc_we = 1, o_pc_sel = taken, o_insn_vld = 1, next S_FETCH.
  - Load/store goes to S_MEM; all others go to S_WB.
- S_MEM:
  - o_dmem_req held (o_dmem_we = 1 for stores) until i_dmem_ready.
  - The address must stay stable; no other enables are asserted while waiting.
  - On ready: a store asserts o_pc_we = 1, pc_sel = 0, o_insn_vld = 1, next S_FETCH; a load goes to S_WB.
- S_WB (1 cycle):
  - o_rd_wren = 1 only if rd != 0.
  - o_wb_sel = 01 for loads, 10 for JAL/JALR, 00 otherwise.
  - o_pc_we = 1 with o_pc_sel = 1 for JAL/JALR, else 0; o_insn_vld = 1; next S_FETCH.
- S_TRAP (1 cycle): o_illegal = 1, o_pc_we = 1, pc_sel = 0, no rd write, next S_FETCH.
- Latency (fetch valid in the first cycle):
  - Branch: 3 cycles.
  - ALU, JAL, LUI: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each extra memory wait cycle adds 1.
- Invariants:
  - o_insn_vld and o_pc_we are asserted exactly once per instruction.
  - o_rd_wren and o_dmem_req are never asserted together.
  - FENCE and ECALL decode as NOP: they go to S_WB with rd_wren = 0.

Decomposition:
- Package ctrl_pkg holds:
  - state_e enum.
  - alu_op_e: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B.
  - imm_sel_e with the 3-bit codes above.
  - RV32I opcode localparams.
  - wb_sel constants.
- One sub-module, ctrl_decode: combinational decode of i_instr into the instruction class, imm_sel, alu_op and illegal flag.

Test Plan:
- 0x00500093 (addi x1,x0,5), i_imem_valid in the first cycle → imm_sel = 000, opb_sel = 1, rd_wren = 1 in cycle 4, pc_sel = 0, one o_insn_vld.
- 0x00309113 (slli x2,x1,3) → imm_sel = 001, alu_op = SLL; 0x40309113 → o_illegal pulse, no rd write.
- 0x00112423 (sw x1,8(x2)), i_dmem_ready low for 3 cycles → imm_sel = 010; dmem_req and dmem_we held 4 cycles; pc_we on the ready cycle; rd_wren never asserted.
- 0x00000463 (beq x0,x0,+8), i_br_equal = 1 → imm_sel = 011, pc_we with pc_sel = 1 in cycle 3. Repeat with i_br_equal = 0 → pc_sel = 0.
- 0x123452B7 (lui x5,0x12345) → imm_sel = 101, alu_op = PASS_B, rd_wren in WB. 0x0000006F (jal x0,0) → imm_sel = 100, rd_wren = 0, pc_sel = 1.
- Load with i_rst_n pulsed low in S_MEM → outputs 0 immediately, no rd write, o_imem_req = 1 on the first clock after release.
